pipeline_control: RTL and testbench

Pipeline sequencing block for the 5-stage MIPS datapath. It is the consumer of the hazard unit's stall/flush requests. It merges those requests with cache handshakes (ihit/dhit), branch/jump redirects and HALT, and drives the per-latch enable/clear pins of the FD, DE, EM and MW pipeline registers and the PC enable. It also holds a one-entry fetch buffer, so an instruction returned during a freeze is not lost. It keeps 32-bit stall and flush counters for performance reporting.

---
 rtl/pipeline_control.sv | 121 ++++++++++++
 tb/tb_pipeline_control.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Pipeline sequencer: merges hazard requests, cache handshakes, redirects and HALT
// into per-latch enable/clear pins, holds a one-entry fetch buffer and perf counters.
module pipeline_control (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stallFD,
    input  logic        flushDE,
    input  logic        flushHALT,
    input  logic        branch_flush,
    input  logic        ihit,
    input  logic [31:0] instr_in,
    input  logic        dmem_req,
    input  logic        dhit,
    input  logic        halt_mw,
    output logic        pc_en,
    output logic        enFD,
    output logic        enDE,
    output logic        enEM,
    output logic        enMW,
    output logic        clrFD,
    output logic        clrDE,
    output logic        clrEM,
    output logic        clrMW,
    output logic [31:0] instr_out,
    output logic        halted,
    output logic        mem_wait,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    state_t      state, state_next;
    logic        ibuf_valid;
    logic [31:0] ibuf;
    logic        freeze, fetch_ok, in_halt, flush_row;

    assign freeze    = dmem_req & ~dhit;
    assign fetch_ok  = ihit | ibuf_valid;
    assign in_halt   = (state == HALTED);
    assign mem_wait  = (state == DWAIT);
    assign instr_out = ibuf_valid ? ibuf : instr_in;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (freeze) state_next = DWAIT;
            DWAIT:   if (dhit)   state_next = RUN;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
        if (halt_mw) state_next = HALTED;
    end

    // Freeze wins over hazards/branches: they are re-presented while latches hold.
    always_comb begin
        pc_en     = 1'b0;
        enFD      = 1'b0;
        enDE      = 1'b0;
        enEM      = 1'b0;
        enMW      = 1'b0;
        clrFD     = 1'b0;
        clrDE     = 1'b0;
        clrEM     = 1'b0;
        clrMW     = 1'b0;
        flush_row = 1'b0;
        if (!(RST || in_halt || halt_mw || freeze)) begin
            enEM  = 1'b1;
            enMW  = 1'b1;
            clrEM = flushHALT;
            if (branch_flush) begin
                flush_row = 1'b1;
                pc_en     = 1'b1;
                enFD      = 1'b1;
                enDE      = 1'b1;
                clrFD     = 1'b1;
                clrDE     = 1'b1;
            end else if (stallFD || flushDE) begin
                enDE  = 1'b1;
                clrDE = 1'b1;
            end else if (!fetch_ok) begin
                enFD  = 1'b1;
                clrFD = 1'b1;
                enDE  = 1'b1;
            end else begin
                pc_en = 1'b1;
                enFD  = 1'b1;
                enDE  = 1'b1;
            end
        end
    end

    // Capture needs pc_en=0 and consume needs enFD&~clrFD, so they never coincide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ibuf_valid <= 1'b0;
            ibuf       <= 32'd0;
        end else if (ihit && !ibuf_valid && !pc_en && !branch_flush && !in_halt) begin
            ibuf_valid <= 1'b1;
            ibuf       <= instr_in;
        end else if ((enFD && !clrFD) || (branch_flush && !freeze)) begin
            ibuf_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halted    <= 1'b0;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            halted <= (state_next == HALTED);
            if (!in_halt && !pc_en) stall_cnt <= stall_cnt + 32'd1;
            if (flush_row)          flush_cnt <= flush_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control with hand-computed expectations.
module tb_pipeline_control;
    logic        CLK = 1'b0;
    logic        RST;
    logic        stallFD, flushDE, flushHALT, branch_flush, ihit, dmem_req, dhit, halt_mw;
    logic [31:0] instr_in;
    logic        pc_en, enFD, enDE, enEM, enMW, clrFD, clrDE, clrEM, clrMW;
    logic [31:0] instr_out, stall_cnt, flush_cnt;
    logic        halted, mem_wait;
    int          errors = 0;
    int          checks = 0;

    pipeline_control dut (
        .CLK(CLK), .RST(RST), .stallFD(stallFD), .flushDE(flushDE), .flushHALT(flushHALT),
        .branch_flush(branch_flush), .ihit(ihit), .instr_in(instr_in), .dmem_req(dmem_req),
        .dhit(dhit), .halt_mw(halt_mw), .pc_en(pc_en), .enFD(enFD), .enDE(enDE), .enEM(enEM),
        .enMW(enMW), .clrFD(clrFD), .clrDE(clrDE), .clrEM(clrEM), .clrMW(clrMW),
        .instr_out(instr_out), .halted(halted), .mem_wait(mem_wait),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Vectors are {pc_en, enFD, enDE, enEM, enMW} and {clrFD, clrDE, clrEM, clrMW}
    task automatic chk_pins(input string tag, input logic [4:0] en_exp, input logic [3:0] clr_exp);
        chk({tag, ".en"},  {27'd0, pc_en, enFD, enDE, enEM, enMW}, {27'd0, en_exp});
        chk({tag, ".clr"}, {28'd0, clrFD, clrDE, clrEM, clrMW},   {28'd0, clr_exp});
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; stallFD = 0; flushDE = 0; flushHALT = 0; branch_flush = 0;
        ihit = 0; instr_in = 32'd0; dmem_req = 0; dhit = 0; halt_mw = 0;
        #2;
        chk_pins("reset", 5'b00000, 4'b0000);
        chk("reset.halted", {31'd0, halted}, 32'd0);
        chk("reset.mem_wait", {31'd0, mem_wait}, 32'd0);
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.flush_cnt", flush_cnt, 32'd0);

        // Free run
        cyc(); RST = 1'b0; ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_in = 32'h1111_0000 + i; #1;
            chk_pins("run", 5'b11111, 4'b0000);
            chk("run.instr", instr_out, 32'h1111_0000 + i);
            cyc();
        end
        chk("run.stall_cnt", stall_cnt, 32'd0);

        // Load-use stall; the fetched instruction is buffered meanwhile
        instr_in = 32'h2222_2222; stallFD = 1'b1; #1;
        chk_pins("stall", 5'b00111, 4'b0100);
        cyc(); stallFD = 1'b0; #1;
        chk("stall.cnt", stall_cnt, 32'd1);
        chk_pins("stall.after", 5'b11111, 4'b0000);
        chk("stall.ibuf", instr_out, 32'h2222_2222);
        cyc(); instr_in = 32'h3333_3333; #1;
        chk("stall.ibuf_cleared", instr_out, 32'h3333_3333);

        // Data miss, 3 frozen cycles then dhit
        cyc(); dmem_req = 1'b1; dhit = 1'b0; ihit = 1'b0; instr_in = 32'hDEAD_0000; #1;
        chk_pins("miss.c1", 5'b00000, 4'b0000);
        chk("miss.c1.mem_wait", {31'd0, mem_wait}, 32'd0);
        cyc(); ihit = 1'b1; instr_in = 32'h8C22_0004; #1;
        chk_pins("miss.c2", 5'b00000, 4'b0000);
        chk("miss.c2.mem_wait", {31'd0, mem_wait}, 32'd1);
        cyc(); ihit = 1'b0; instr_in = 32'hBAD0_0000; #1;
        chk("miss.c3.mem_wait", {31'd0, mem_wait}, 32'd1);
        chk("miss.c3.instr", instr_out, 32'h8C22_0004);
        cyc(); dhit = 1'b1; #1;
        chk("miss.c4.mem_wait", {31'd0, mem_wait}, 32'd1);
        chk_pins("miss.c4", 5'b11111, 4'b0000);
        chk("miss.c4.instr", instr_out, 32'h8C22_0004);
        cyc(); dmem_req = 1'b0; dhit = 1'b0; ihit = 1'b1; instr_in = 32'h4444_4444; #1;
        chk("miss.done.mem_wait", {31'd0, mem_wait}, 32'd0);
        chk("miss.stall_cnt", stall_cnt, 32'd4);
        chk("miss.done.instr", instr_out, 32'h4444_4444);

        // Single-cycle dhit: no DWAIT, no stall
        cyc(); dmem_req = 1'b1; dhit = 1'b1; #1;
        chk_pins("hit1", 5'b11111, 4'b0000);
        cyc(); dmem_req = 1'b0; dhit = 1'b0; #1;
        chk("hit1.mem_wait", {31'd0, mem_wait}, 32'd0);
        chk("hit1.stall_cnt", stall_cnt, 32'd4);

        // Instruction miss: FD bubble
        ihit = 1'b0; #1;
        chk_pins("imiss", 5'b01111, 4'b1000);
        cyc(); ihit = 1'b1; #1;
        chk("imiss.stall_cnt", stall_cnt, 32'd5);

        // Buffer an instruction via flushDE, then a branch (with stallFD) discards it
        instr_in = 32'h5555_5555; flushDE = 1'b1; #1;
        chk_pins("flushDE", 5'b00111, 4'b0100);
        cyc(); flushDE = 1'b0; branch_flush = 1'b1; stallFD = 1'b1; instr_in = 32'h6666_6666; #1;
        chk_pins("branch", 5'b11111, 4'b1100);
        chk("branch.instr", instr_out, 32'h5555_5555);
        chk("branch.stall_cnt", stall_cnt, 32'd6);
        cyc(); branch_flush = 1'b0; stallFD = 1'b0; #1;
        chk("branch.flush_cnt", flush_cnt, 32'd1);
        chk("branch.ibuf_discarded", instr_out, 32'h6666_6666);

        // Store squash behind HALT
        flushHALT = 1'b1; #1;
        chk_pins("flushHALT", 5'b11111, 4'b0010);
        cyc(); flushHALT = 1'b0;

        // HALT
        halt_mw = 1'b1; #1;
        chk_pins("halt", 5'b00000, 4'b0000);
        chk("halt.halted_pre", {31'd0, halted}, 32'd0);
        cyc(); halt_mw = 1'b0; #1;
        chk("halt.halted", {31'd0, halted}, 32'd1);
        chk("halt.stall_cnt", stall_cnt, 32'd7);
        branch_flush = 1'b1; ihit = 1'b1; dmem_req = 1'b1;
        cyc(); cyc(); #1;
        chk_pins("halted.hold", 5'b00000, 4'b0000);
        chk("halted.hold.halted", {31'd0, halted}, 32'd1);
        chk("halted.stall_cnt", stall_cnt, 32'd7);
        chk("halted.flush_cnt", flush_cnt, 32'd1);
        chk("halted.mem_wait", {31'd0, mem_wait}, 32'd0);

        // Reset out of HALTED
        RST = 1'b1; branch_flush = 1'b0; dmem_req = 1'b0; #1;
        chk("rst2.halted", {31'd0, halted}, 32'd0);
        chk("rst2.stall_cnt", stall_cnt, 32'd0);
        chk("rst2.flush_cnt", flush_cnt, 32'd0);
        chk_pins("rst2", 5'b00000, 4'b0000);
        cyc(); RST = 1'b0; instr_in = 32'h7777_7777; #1;
        chk_pins("rst2.run", 5'b11111, 4'b0000);
        chk("rst2.instr", instr_out, 32'h7777_7777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
